// File: rtl/status_reg_decoder.sv
`default_nettype none
// ============================================================================
// status_reg_decoder : {n,p,z,c} status register, flag legality check and
//                      registered branch decision over valid/ready. Rev 1.0
// ============================================================================
module status_reg_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flags_in,
  input  logic             cond_valid,
  output logic             cond_ready,
  input  logic [4:0]       cond_code,
  output logic             taken_valid,
  output logic             taken,
  input  logic             taken_ready,
  output logic [3:0]       status_q,
  output logic             flag_err,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t state;

  logic       flags_legal;
  logic       write_ok;
  logic [3:0] eval_flags;
  logic       decision;
  logic       accept;
  logic       complete;

  // n and p are mutually exclusive and exactly one is set; a zero result cannot be negative
  assign flags_legal = (flags_in[3] != flags_in[2]) && !(flags_in[1] && flags_in[3]);
  assign write_ok    = flag_we && flags_legal;
  assign eval_flags  = write_ok ? flags_in : status_q;
  assign decision    = cond_code[4] ^ (|(cond_code[3:0] & eval_flags));

  assign cond_ready  = !taken_valid || taken_ready;
  assign accept      = cond_valid && cond_ready;
  assign complete    = taken_valid && taken_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      status_q    <= 4'b0110;
      flag_err    <= 1'b0;
      taken_valid <= 1'b0;
      taken       <= 1'b0;
      taken_count <= '0;
    end else begin
      if (write_ok) begin
        status_q <= flags_in;
      end else if (flag_we) begin
        flag_err <= 1'b1;
      end

      if (complete && taken && (taken_count != {CNT_W{1'b1}})) begin
        taken_count <= taken_count + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_RESP;
            taken_valid <= 1'b1;
            taken       <= decision;
          end
        end
        ST_RESP: begin
          // Without taken_ready the latched decision is held untouched
          if (taken_ready) begin
            if (accept) begin
              taken <= decision;
            end else begin
              state       <= ST_IDLE;
              taken_valid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          taken_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_status_reg_decoder.sv
`default_nettype none
// ============================================================================
// tb_status_reg_decoder : directed self-checking bench for status_reg_decoder
// ============================================================================
module tb_status_reg_decoder;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [3:0] flags_in;
  logic       cond_valid;
  logic       cond_ready;
  logic [4:0] cond_code;
  logic       taken_valid;
  logic       taken;
  logic       taken_ready;
  logic [3:0] status_q;
  logic       flag_err;
  logic [1:0] taken_count;

  int         n_cmp;
  int         n_bad;
  logic [1:0] exp_cnt;

  status_reg_decoder #(.CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flag_we     (flag_we),
    .flags_in    (flags_in),
    .cond_valid  (cond_valid),
    .cond_ready  (cond_ready),
    .cond_code   (cond_code),
    .taken_valid (taken_valid),
    .taken       (taken),
    .taken_ready (taken_ready),
    .status_q    (status_q),
    .flag_err    (flag_err),
    .taken_count (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are observed 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cond_valid = 1'b1; cond_code = 5'b00010;
    flag_we = 1'b0; flags_in = 4'b0000; taken_ready = 1'b1;
    step(); step();
    exp_cnt = 2'd0;
    n_cmp++; if (status_q !== 4'b0110) begin n_bad++; $display("FAIL reset_status got=%b want=0110", status_q); end
    n_cmp++; if (taken_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", taken_valid); end
    n_cmp++; if (flag_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", flag_err); end
    n_cmp++; if (taken_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", taken_count); end
    n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken got=%b want=0", taken); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b1) begin n_bad++; $display("FAIL first_z valid=%b taken=%b want 1/1", taken_valid, taken); end
    cond_valid = 1'b0;
    step(); bump();
    n_cmp++; if (taken_valid !== 1'b0) begin n_bad++; $display("FAIL first_idle got=%b want=0", taken_valid); end
    n_cmp++; if (taken_count !== exp_cnt) begin n_bad++; $display("FAIL first_count got=%0d want=%0d", taken_count, exp_cnt); end
  endtask

  task automatic test_flag_eval();
    flag_we = 1'b1; flags_in = 4'b1000;
    step();
    flag_we = 1'b0;
    n_cmp++; if (status_q !== 4'b1000) begin n_bad++; $display("FAIL write_n got=%b want=1000", status_q); end
    cond_valid = 1'b1; cond_code = 5'b01000;
    step();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b1) begin n_bad++; $display("FAIL eval_n valid=%b taken=%b want 1/1", taken_valid, taken); end
    cond_code = 5'b00100;
    step(); bump();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b0) begin n_bad++; $display("FAIL eval_p valid=%b taken=%b want 1/0", taken_valid, taken); end
    cond_code = 5'b10100;
    step();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b1) begin n_bad++; $display("FAIL eval_not_p valid=%b taken=%b want 1/1", taken_valid, taken); end
    cond_code = 5'b00000;
    step();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b0) begin n_bad++; $display("FAIL eval_never valid=%b taken=%b want 1/0", taken_valid, taken); end
    cond_valid = 1'b0;
    step(); bump();
    n_cmp++; if (taken_count !== exp_cnt) begin n_bad++; $display("FAIL eval_count got=%0d want=%0d", taken_count, exp_cnt); end
  endtask

  task automatic test_forwarding();
    flag_we = 1'b1; flags_in = 4'b0100;
    step();
    n_cmp++; if (status_q !== 4'b0100) begin n_bad++; $display("FAIL fwd_setup got=%b want=0100", status_q); end
    flags_in = 4'b1000; cond_valid = 1'b1; cond_code = 5'b01000;
    step();
    flag_we = 1'b0; cond_valid = 1'b0;
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b1) begin n_bad++; $display("FAIL fwd_taken valid=%b taken=%b want 1/1", taken_valid, taken); end
    n_cmp++; if (status_q !== 4'b1000) begin n_bad++; $display("FAIL fwd_status got=%b want=1000", status_q); end
    step(); bump();
  endtask

  task automatic test_illegal();
    flag_we = 1'b1; flags_in = 4'b1100; cond_valid = 1'b1; cond_code = 5'b00100;
    step();
    cond_valid = 1'b0; flags_in = 4'b1010;
    n_cmp++; if (status_q !== 4'b1000) begin n_bad++; $display("FAIL ill_np_status got=%b want=1000", status_q); end
    n_cmp++; if (flag_err !== 1'b1) begin n_bad++; $display("FAIL ill_np_err got=%b want=1", flag_err); end
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b0) begin n_bad++; $display("FAIL ill_no_fwd valid=%b taken=%b want 1/0", taken_valid, taken); end
    step();
    flag_we = 1'b0;
    n_cmp++; if (status_q !== 4'b1000) begin n_bad++; $display("FAIL ill_zn_status got=%b want=1000", status_q); end
    step();
    n_cmp++; if (flag_err !== 1'b1) begin n_bad++; $display("FAIL ill_sticky got=%b want=1", flag_err); end
  endtask

  task automatic test_back_to_back();
    taken_ready = 1'b0; cond_valid = 1'b1; cond_code = 5'b10000;
    step();
    cond_code = 5'b00000;
    n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready got=%b want=0", cond_ready); end
    for (int i = 0; i < 3; i++) begin
      flag_we = (i == 1); flags_in = 4'b0100;
      step();
      n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b1 || cond_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] valid=%b taken=%b ready=%b want 1/1/0", i, taken_valid, taken, cond_ready);
      end
    end
    flag_we = 1'b0; taken_ready = 1'b1;
    step(); bump();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b0) begin n_bad++; $display("FAIL b2b_first valid=%b taken=%b want 1/0", taken_valid, taken); end
    cond_code = 5'b10000;
    step();
    n_cmp++; if (taken_valid !== 1'b1 || taken !== 1'b1) begin n_bad++; $display("FAIL b2b_second valid=%b taken=%b want 1/1", taken_valid, taken); end
    cond_valid = 1'b0;
    step(); bump();
    n_cmp++; if (taken_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b want=0", taken_valid); end
    n_cmp++; if (taken_count !== exp_cnt) begin n_bad++; $display("FAIL b2b_count got=%0d want=%0d", taken_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; exp_cnt = 2'd0;
    n_cmp++; if (taken_count !== 2'd0) begin n_bad++; $display("FAIL sat_clear got=%0d want=0", taken_count); end
    cond_valid = 1'b1; cond_code = 5'b10000; taken_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k > 1) bump();
      n_cmp++; if (taken_count !== exp_cnt) begin n_bad++; $display("FAIL sat_count[%0d] got=%0d want=%0d", k, taken_count, exp_cnt); end
    end
    cond_valid = 1'b0;
    step(); bump();
    step();
    n_cmp++; if (taken_count !== 2'd3) begin n_bad++; $display("FAIL sat_hold got=%0d want=3", taken_count); end
  endtask

  task automatic test_reset_mid();
    cond_valid = 1'b1; cond_code = 5'b10000; taken_ready = 1'b0;
    step();
    n_cmp++; if (taken_valid !== 1'b1) begin n_bad++; $display("FAIL mid_setup got=%b want=1", taken_valid); end
    rst_n = 1'b0; taken_ready = 1'b1;
    step();
    n_cmp++; if (taken_valid !== 1'b0 || taken !== 1'b0) begin n_bad++; $display("FAIL mid_drop valid=%b taken=%b want 0/0", taken_valid, taken); end
    n_cmp++; if (taken_count !== 2'd0) begin n_bad++; $display("FAIL mid_count got=%0d want=0", taken_count); end
    rst_n = 1'b1; cond_valid = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_cnt = 2'd0;
    test_reset();
    test_flag_eval();
    test_forwarding();
    test_illegal();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/status_reg_decoder.md
Name: status_reg_decoder

Overview:
- Consumer side of the {n,p,z,c} status encoding produced at the ALU output.
- Holds the architectural status register and checks each incoming flag write for legality.
- Evaluates branch-condition requests against the held (or same-cycle forwarded) flags and returns a registered taken/not-taken decision over a valid/ready handshake.
- Sits between the ALU status encoder and the fetch/PC-update logic.

Parameters:
- CNT_W, 8, width of the saturating taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- flag_we  input  1  write strobe for flags_in.
- flags_in  input  4  encoded flags {n,p,z,c}.
- cond_valid  input  1  branch-condition request valid.
- cond_ready  output  1  block can accept a request this cycle.
- cond_code  input  5  bit4 = invert, bits3:0 = mask over {n,p,z,c}.
- taken_valid  output  1  decision available.
- taken  output  1  decision value; meaningful only while taken_valid=1.
- taken_ready  input  1  downstream accepts the decision.
- status_q  output  4  current status register {n,p,z,c}.
- flag_err  output  1  sticky: an illegal flags_in write was rejected.
- taken_count  output  CNT_W  saturating count of accepted taken=1 decisions.

Behaviour:
- Reset (rst_n=0 at a clk edge): status_q=4'b0110 (zero result, no carry), flag_err=0, taken_valid=0, taken=0, taken_count=0. Reset overrides every other input in the same cycle.
- Reset asserted mid-transaction: a pending decision is dropped; no handshake completes in that cycle.
- Flag legality: flags_in is legal iff n!=p and not (z&&n).
- Legal write: flag_we=1 with legal flags_in updates status_q at the next edge.
- Illegal write: status_q is left unchanged and flag_err is set; flag_err clears only on reset.
- Condition function: taken = cond_code[4] XOR |(cond_code[3:0] & F).
  - mask 0000, invert 0 gives never taken; mask 0000, invert 1 gives always taken.
- Flags used for evaluation (F): if flag_we=1 with legal flags_in in the same cycle the request is accepted, F = flags_in (forwarding). Otherwise F = status_q. An illegal same-cycle write is not forwarded.
- FSM states:
  - IDLE: taken_valid=0.
  - RESP: taken_valid=1, taken holds the decision.
- Handshake:
  - cond_ready = !taken_valid || taken_ready (combinational).
  - A request is accepted when cond_valid && cond_ready.
  - Latency is one cycle: accept at edge T gives taken_valid=1 and taken valid in the cycle after T.
- Transitions:
  - IDLE, accept: go to RESP, load taken.
  - IDLE, no accept: stay.
  - RESP, taken_ready=1 and a new accept in the same cycle: stay in RESP, load the new taken (back-to-back, one decision per cycle).
  - RESP, taken_ready=1 and no accept: go to IDLE.
  - RESP, taken_ready=0: stay; taken and taken_valid stay stable; cond_ready=0.
- taken_count increments by 1 when a taken=1 decision completes its handshake (taken_valid && taken_ready && taken). It saturates at 2^CNT_W-1 and never wraps.
- A flag write while in RESP does not alter the already-latched taken.
- All outputs other than cond_ready are registered.

Test Plan:
- Reset behaviour: hold rst_n=0 for 2 cycles with cond_valid=1 -> status_q=0110, taken_valid=0, flag_err=0, taken_count=0. After release, cond_code=5'b00010 (z) is accepted and gives taken=1 one cycle later.
- Flag write and evaluation: write flags_in=1000 (n), then request cond_code=5'b01000 -> taken=1. Request 5'b00100 (p) -> taken=0. Request 5'b10100 (not p) -> taken=1.
- Forwarding: status_q=0100; in the same cycle flag_we=1, flags_in=1000 and cond_code=5'b01000 accepted -> taken=1 next cycle; status_q=1000.
- Illegal write: flags_in=1100, then flags_in=1010 -> status_q unchanged, flag_err=1 sticky. A same-cycle request evaluates against the old status_q.
- Backpressure: taken_ready=0 for 3 cycles after a decision -> taken_valid and taken stable, cond_ready=0. Then taken_ready=1 with cond_valid=1 -> back-to-back decisions with no idle bubble.
- Counter saturation: CNT_W=2, five accepted always-taken requests (cond_code=5'b10000) -> taken_count reaches 3 and stays 3. Reset mid-RESP -> taken_valid=0 next cycle.
